// File: rtl/count_sequencer_if.sv
// Control and status bundle for count_sequencer.
// The master drives the run controls; the slave (the sequencer) drives the count status.
interface count_sequencer_if #(
    parameter int unsigned WIDTH = 6
);
    logic             start;
    logic             pause;
    logic             tick;
    logic             dir;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] stop_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             match;
    logic             done;

    modport master (
        output start, pause, tick, dir, start_val, stop_val,
        input  count, busy, match, done
    );

    modport slave (
        input  start, pause, tick, dir, start_val, stop_val,
        output count, busy, match, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Up/down run counter: counts from a latched start value toward a latched stop value.
// It supports pause and tick gating, and emits a one-cycle done pulse on reaching the stop value.
module count_sequencer #(
    parameter int unsigned WIDTH = 6
) (
    input logic              clk_i,
    input logic              rst_i,
    count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] stop_q,  stop_d;
    logic             dir_q,   dir_d;
    logic             match;

    // Match is only meaningful while actively running.
    assign match = (state_q == StRun) && (count_q == stop_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stop_d  = stop_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    count_d = bus.start_val;
                    stop_d  = bus.stop_val;
                    dir_d   = bus.dir;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (match) begin
                    state_d = StDone;
                end else if (bus.pause) begin
                    state_d = StPause;
                end else if (bus.tick) begin
                    count_d = dir_q ? count_q + 1'b1 : count_q - 1'b1;
                end
            end
            StPause: begin
                if (!bus.pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            stop_q  <= '0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stop_q  <= stop_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == StRun) || (state_q == StPause);
    assign bus.match = match;
    assign bus.done  = (state_q == StDone);
endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer with hand-computed expected values.
module tb_count_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    count_sequencer_if #(.WIDTH(6)) bus ();

    count_sequencer #(.WIDTH(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int sv, input int pv, input logic d);
        bus.start_val = 6'(sv);
        bus.stop_val  = 6'(pv);
        bus.dir       = d;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0; bus.dir = 1'b1;
        bus.start_val = '0; bus.stop_val = '0;
        step(); step();
        check("rst_count", bus.count, 0);
        check("rst_busy",  bus.busy,  0);
        check("rst_match", bus.match, 0);
        check("rst_done",  bus.done,  0);
        rst = 1'b0;

        // Up count 3 -> 5; inputs scrambled after launch must not matter.
        bus.tick = 1'b1;
        launch(3, 5, 1'b1);
        bus.start_val = 6'd40; bus.stop_val = 6'd9; bus.dir = 1'b0;
        check("up_c0", bus.count, 3);
        check("up_busy", bus.busy, 1);
        check("up_m0", bus.match, 0);
        step(); check("up_c1", bus.count, 4);
        step(); check("up_c2", bus.count, 5); check("up_match", bus.match, 1);
        step(); check("up_done", bus.done, 1); check("up_dbusy", bus.busy, 0);
        check("up_dcount", bus.count, 5); check("up_dmatch", bus.match, 0);
        step(); check("up_done_off", bus.done, 0); check("up_idle_c", bus.count, 5);

        // Down with wrap 1 -> 0 -> 63 -> 62.
        launch(1, 62, 1'b0);
        check("dn_c0", bus.count, 1);
        step(); check("dn_c1", bus.count, 0);
        step(); check("dn_wrap", bus.count, 63); check("dn_nomatch", bus.match, 0);
        step(); check("dn_c3", bus.count, 62); check("dn_match", bus.match, 1);
        step(); check("dn_done", bus.done, 1);
        step(); check("dn_done_off", bus.done, 0); check("dn_hold", bus.count, 62);

        // Idle with start low holds everything.
        bus.start_val = 6'd7; bus.stop_val = 6'd8; bus.dir = 1'b1;
        step(); step(); step();
        check("idle_hold", bus.count, 62); check("idle_busy", bus.busy, 0);

        // Pause and tick gating, run 10 -> 20.
        launch(10, 20, 1'b1);
        check("pt_c0", bus.count, 10);
        step(); check("pt_c1", bus.count, 11);
        bus.pause = 1'b1;
        step(); check("pt_p1", bus.count, 11); check("pt_pbusy", bus.busy, 1);
        check("pt_pmatch", bus.match, 0);
        bus.tick = 1'b0;
        step(); check("pt_p2", bus.count, 11);
        bus.tick = 1'b1;
        step(); check("pt_p3", bus.count, 11); check("pt_pbusy3", bus.busy, 1);
        bus.pause = 1'b0;
        step(); check("pt_resume", bus.count, 11); check("pt_rbusy", bus.busy, 1);
        step(); check("pt_tick1", bus.count, 12);
        bus.tick = 1'b0;
        step(); check("pt_tick0", bus.count, 12);
        bus.tick = 1'b1;
        step(); check("pt_tick1b", bus.count, 13);
        for (int i = 0; i < 7; i++) step();
        check("pt_end", bus.count, 20); check("pt_match", bus.match, 1);
        bus.pause = 1'b1;  // match outranks pause
        step(); check("pt_done", bus.done, 1); check("pt_dcount", bus.count, 20);
        bus.pause = 1'b0;
        step(); check("pt_idle", bus.busy, 0); check("pt_done_off", bus.done, 0);

        // Start equals stop: one matching RUN cycle, then done.
        launch(17, 17, 1'b1);
        check("eq_c", bus.count, 17); check("eq_match", bus.match, 1);
        step(); check("eq_done", bus.done, 1); check("eq_dcount", bus.count, 17);
        step(); check("eq_done_off", bus.done, 0); check("eq_idle_c", bus.count, 17);

        // Abort 10 -> 50 at 40, with ignored start pulses mid-run.
        launch(10, 50, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (i >= 5 && i <= 7) begin
                bus.start = 1'b1; bus.start_val = 6'd5; bus.dir = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            step();
            if (i == 8) check("ab_ignore", bus.count, 19);
        end
        check("ab_c40", bus.count, 40);
        rst = 1'b1;
        step();
        check("ab_count", bus.count, 0); check("ab_busy", bus.busy, 0);
        check("ab_done", bus.done, 0); check("ab_match", bus.match, 0);
        rst = 1'b0;
        step(); check("ab_nodone", bus.done, 0); check("ab_idle_c", bus.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
